// File: rtl/dpram_be_init.sv
// dpram_be_init: true dual-port scratch RAM shared by two requesters on one clock.
// Per-byte write enables, registered read data with a valid strobe, and a
// selectable read-during-write mode. On a same-address double write port 1
// owns its enabled lanes. After reset a sweep writes InitValue to every word
// before any request is accepted.
module dpram_be_init #(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 32,
  parameter int Depth     = 16,
  parameter int ByteWidth = 8,
  parameter int RdMode    = 0,
  parameter logic [DataWidth-1:0] InitValue = '0,
  localparam int NB = DataWidth / ByteWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 wr1,
  input  logic                 rd1,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [DataWidth-1:0] Wrdata1,
  input  logic [NB-1:0]        be1,
  output logic [DataWidth-1:0] Rddata1,
  output logic                 Rdvalid1,
  input  logic                 wr2,
  input  logic                 rd2,
  input  logic [AddrWidth-1:0] addr2,
  input  logic [DataWidth-1:0] Wrdata2,
  input  logic [NB-1:0]        be2,
  output logic [DataWidth-1:0] Rddata2,
  output logic                 Rdvalid2,
  output logic                 busy,
  output logic                 collision,
  output logic                 addr_err
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  localparam int AW1 = AddrWidth + 1;
  // Depth may equal 2**AddrWidth, so range checks use one extra bit.
  localparam logic [AddrWidth:0]   DepthW   = AW1'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  state_e               state_q;
  logic [AddrWidth-1:0] clr_cnt_q;
  logic                 busy_q;
  logic [DataWidth-1:0] mem [Depth];

  logic                 acc;
  logic                 in1, in2;
  logic                 we1, we2;
  logic                 re1, re2;
  logic                 same_addr;
  logic [DataWidth-1:0] old1, old2;
  logic [DataWidth-1:0] fwd1, fwd2;
  logic [DataWidth-1:0] rd_word1, rd_word2;

  // Requests only count once the sweep is done and the chip is selected.
  assign acc       = cs & ~busy_q & ~rst;
  assign in1       = ({1'b0, addr1} < DepthW);
  assign in2       = ({1'b0, addr2} < DepthW);
  assign we1       = acc & wr1 & in1;
  assign we2       = acc & wr2 & in2;
  assign re1       = acc & rd1;
  assign re2       = acc & rd2;
  assign same_addr = (addr1 == addr2);

  // Out-of-range reads return zero rather than whatever the array holds.
  assign old1 = in1 ? mem[addr1] : '0;
  assign old2 = in2 ? mem[addr2] : '0;

  // Post-write view of each read address, lane by lane, port 1 winning.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign fwd1[gi*ByteWidth +: ByteWidth] =
        (we1 & be1[gi])             ? Wrdata1[gi*ByteWidth +: ByteWidth] :
        (we2 & be2[gi] & same_addr) ? Wrdata2[gi*ByteWidth +: ByteWidth] :
                                      old1[gi*ByteWidth +: ByteWidth];
    assign fwd2[gi*ByteWidth +: ByteWidth] =
        (we1 & be1[gi] & same_addr) ? Wrdata1[gi*ByteWidth +: ByteWidth] :
        (we2 & be2[gi])             ? Wrdata2[gi*ByteWidth +: ByteWidth] :
                                      old2[gi*ByteWidth +: ByteWidth];
  end

  assign rd_word1 = (RdMode == 1) ? fwd1 : old1;
  assign rd_word2 = (RdMode == 1) ? fwd2 : old2;

  // Clear-sweep sequencer: walk every word once after reset, then go ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == LastAddr) begin
        state_q   <= ST_READY;
        clr_cnt_q <= '0;
        busy_q    <= 1'b0;
      end else begin
        clr_cnt_q <= clr_cnt_q + AddrWidth'(1);
      end
    end
  end

  // Array writes: sweep fill, or byte-lane writes with port 1 issued last so it wins.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      if (!rst) begin
        mem[clr_cnt_q] <= InitValue;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (we2 && be2[k]) begin
          mem[addr2][k*ByteWidth +: ByteWidth] <= Wrdata2[k*ByteWidth +: ByteWidth];
        end
        if (we1 && be1[k]) begin
          mem[addr1][k*ByteWidth +: ByteWidth] <= Wrdata1[k*ByteWidth +: ByteWidth];
        end
      end
    end
  end

  // Registered read data, valid strobes and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      Rddata1   <= '0;
      Rddata2   <= '0;
      Rdvalid1  <= 1'b0;
      Rdvalid2  <= 1'b0;
      collision <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      Rdvalid1  <= re1;
      Rdvalid2  <= re2;
      if (re1) begin
        Rddata1 <= rd_word1;
      end
      if (re2) begin
        Rddata2 <= rd_word2;
      end
      collision <= we1 & we2 & same_addr;
      addr_err  <= acc & (((wr1 | rd1) & ~in1) | ((wr2 | rd2) & ~in2));
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_dpram_be_init.sv
// Bench for dpram_be_init: three instances (read-first, write-first, Depth=12)
// share one stimulus stream and are checked each cycle against a word-array model.
module tb_dpram_be_init;

  localparam logic [31:0] INIT = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst, cs, wr1, rd1, wr2, rd2;
  logic [3:0]  addr1, addr2, be1, be2;
  logic [31:0] wd1, wd2;

  logic [31:0] rdd1 [3];
  logic [31:0] rdd2 [3];
  logic        rdv1 [3];
  logic        rdv2 [3];
  logic        busy_o [3];
  logic        coll_o [3];
  logic        err_o [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dpram_be_init #(
      .AddrWidth(4), .DataWidth(32), .Depth((gi == 2) ? 12 : 16),
      .ByteWidth(8), .RdMode((gi == 1) ? 1 : 0), .InitValue(INIT)
    ) u_dut (
      .clk(clk), .rst(rst), .cs(cs),
      .wr1(wr1), .rd1(rd1), .addr1(addr1), .Wrdata1(wd1), .be1(be1),
      .Rddata1(rdd1[gi]), .Rdvalid1(rdv1[gi]),
      .wr2(wr2), .rd2(rd2), .addr2(addr2), .Wrdata2(wd2), .be2(be2),
      .Rddata2(rdd2[gi]), .Rdvalid2(rdv2[gi]),
      .busy(busy_o[gi]), .collision(coll_o[gi]), .addr_err(err_o[gi])
    );
  end

  // Reference model state, one set per instance.
  logic [31:0] mm [3][16];
  int          rem [3];
  logic [31:0] e_rdd1 [3];
  logic [31:0] e_rdd2 [3];
  logic        e_v1 [3];
  logic        e_v2 [3];
  logic        e_busy [3];
  logic        e_coll [3];
  logic        e_err [3];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  function automatic int dep(int i);
    return (i == 2) ? 12 : 16;
  endfunction

  function automatic logic [68:0] obs_vec(int i);
    return {rdv1[i], rdd1[i], rdv2[i], rdd2[i], busy_o[i], coll_o[i], err_o[i]};
  endfunction

  function automatic logic [68:0] exp_vec(int i);
    return {e_v1[i], e_rdd1[i], e_v2[i], e_rdd2[i], e_busy[i], e_coll[i], e_err[i]};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int d;
      logic acc, in1, in2;
      logic [31:0] old [16];
      d = dep(i);
      if (rst) begin
        rem[i] = d; e_busy[i] = 1'b1;
        e_rdd1[i] = '0; e_rdd2[i] = '0; e_v1[i] = 1'b0; e_v2[i] = 1'b0;
        e_coll[i] = 1'b0; e_err[i] = 1'b0;
      end else if (rem[i] > 0) begin
        mm[i][d - rem[i]] = INIT;
        rem[i]--;
        e_busy[i] = (rem[i] > 0);
        e_v1[i] = 1'b0; e_v2[i] = 1'b0; e_coll[i] = 1'b0; e_err[i] = 1'b0;
      end else begin
        acc = cs;
        in1 = int'(addr1) < d;
        in2 = int'(addr2) < d;
        for (int a = 0; a < 16; a++) old[a] = mm[i][a];
        for (int k = 0; k < 4; k++)
          if (acc && wr2 && in2 && be2[k]) mm[i][addr2][8*k +: 8] = wd2[8*k +: 8];
        for (int k = 0; k < 4; k++)
          if (acc && wr1 && in1 && be1[k]) mm[i][addr1][8*k +: 8] = wd1[8*k +: 8];
        e_v1[i] = acc && rd1;
        e_v2[i] = acc && rd2;
        if (acc && rd1) e_rdd1[i] = !in1 ? 32'h0 : ((i == 1) ? mm[i][addr1] : old[addr1]);
        if (acc && rd2) e_rdd2[i] = !in2 ? 32'h0 : ((i == 1) ? mm[i][addr2] : old[addr2]);
        e_coll[i] = acc && wr1 && wr2 && in1 && in2 && (addr1 == addr2);
        e_err[i]  = acc && (((wr1 || rd1) && !in1) || ((wr2 || rd2) && !in2));
        e_busy[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    $display("cyc %0d rst=%0b cs=%0b p1 wr=%0b rd=%0b a=%0d d=%h be=%h | p2 wr=%0b rd=%0b a=%0d d=%h be=%h",
             cyc, rst, cs, wr1, rd1, addr1, wd1, be1, wr2, rd2, addr2, wd2, be2);
  endtask

  task automatic idle();
    rst = 1'b0; cs = 1'b1;
    wr1 = 1'b0; rd1 = 1'b0; addr1 = '0; wd1 = '0; be1 = '0;
    wr2 = 1'b0; rd2 = 1'b0; addr2 = '0; wd2 = '0; be2 = '0;
  endtask

  task automatic test_reset();
    int c0, c2;
    idle(); rst = 1'b1;
    repeat (3) begin
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL reset inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
    end
    rst = 1'b0; c0 = 0; c2 = 0;
    while (busy_o[0] === 1'b1 && c0 < 40) begin
      if (busy_o[2] === 1'b1) c2++;
      step(); c0++;
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL clear inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
    end
    nvec++;
    if (c0 != 16) begin nerr++; $display("FAIL busy_cycles_d16 got %0d want 16", c0); end
    nvec++;
    if (c2 != 12) begin nerr++; $display("FAIL busy_cycles_d12 got %0d want 12", c2); end
    for (int a = 0; a < 16; a++) begin
      idle(); rd1 = 1'b1; addr1 = 4'(a); rd2 = 1'b1; addr2 = 4'(15 - a);
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL readinit inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
      nvec++;
      if (rdd1[0] !== INIT || rdv1[0] !== 1'b1) begin
        nerr++; $display("FAIL readinit_word a=%0d got %h/%0b want %h/1", a, rdd1[0], rdv1[0], INIT);
      end
    end
  endtask

  task automatic test_dual_sweep();
    for (int a = 0; a < 20; a++) begin
      idle();
      if (a < 10) begin
        wr1 = 1'b1; addr1 = 4'(a); wd1 = $urandom; be1 = 4'hF;
        wr2 = 1'b1; addr2 = 4'(15 - a); wd2 = $urandom; be2 = 4'hF;
      end else begin
        rd1 = 1'b1; addr1 = 4'(a - 10); rd2 = 1'b1; addr2 = 4'(25 - a);
      end
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL dual inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
      nvec++;
      if (coll_o[0] !== 1'b0) begin nerr++; $display("FAIL dual_collision cyc%0d got %0b want 0", cyc, coll_o[0]); end
    end
  endtask

  task automatic test_byte_lanes();
    for (int s = 0; s < 4; s++) begin
      idle();
      case (s)
        0: begin wr1 = 1'b1; addr1 = 4'd5; wd1 = 32'h0; be1 = 4'hF; end
        1: begin
          wr1 = 1'b1; addr1 = 4'd5; wd1 = 32'h11223344; be1 = 4'b0011;
          wr2 = 1'b1; addr2 = 4'd5; wd2 = 32'hAABBCCDD; be2 = 4'b0110;
        end
        2: begin rd1 = 1'b1; addr1 = 4'd5; end
        default: ;
      endcase
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL lanes inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
      if (s == 1) begin
        nvec++;
        if (coll_o[0] !== 1'b1) begin nerr++; $display("FAIL lanes_collision got %0b want 1", coll_o[0]); end
      end
      if (s == 2) begin
        nvec++;
        if (rdd1[0] !== 32'h00BB3344) begin nerr++; $display("FAIL lanes_word got %h want 00bb3344", rdd1[0]); end
      end
    end
  endtask

  task automatic test_rdw();
    for (int s = 0; s < 2; s++) begin
      idle();
      wr1 = 1'b1; addr1 = 4'd3; be1 = 4'hF;
      wd1 = (s == 0) ? 32'h0 : 32'hCAFEF00D;
      if (s == 1) begin rd2 = 1'b1; addr2 = 4'd3; end
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL rdw inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
      if (s == 1) begin
        nvec++;
        if (rdd2[0] !== 32'h0) begin nerr++; $display("FAIL rdw_readfirst got %h want 00000000", rdd2[0]); end
        nvec++;
        if (rdd2[1] !== 32'hCAFEF00D) begin nerr++; $display("FAIL rdw_writefirst got %h want cafef00d", rdd2[1]); end
      end
    end
  endtask

  task automatic test_gating();
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin wr1 = 1'b1; addr1 = 4'd2; wd1 = 32'h5A5A0F0F; be1 = 4'hF; end
        1: begin cs = 1'b0; wr1 = 1'b1; addr1 = 4'd2; wd1 = 32'h12345678; be1 = 4'hF; rd2 = 1'b1; addr2 = 4'd2; end
        2: begin rd1 = 1'b1; addr1 = 4'd2; end
        3: begin wr1 = 1'b1; addr1 = 4'd13; wd1 = $urandom; be1 = 4'hF; end
        default: begin rd1 = 1'b1; addr1 = 4'd13; end
      endcase
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL gating inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
      if (s == 1) begin
        nvec++;
        if (rdv2[0] !== 1'b0) begin nerr++; $display("FAIL cs0_rdvalid got %0b want 0", rdv2[0]); end
      end
      if (s == 2) begin
        nvec++;
        if (rdd1[0] !== 32'h5A5A0F0F) begin nerr++; $display("FAIL cs0_nowrite got %h want 5a5a0f0f", rdd1[0]); end
      end
      if (s == 3) begin
        nvec++;
        if (err_o[2] !== 1'b1) begin nerr++; $display("FAIL range_err got %0b want 1", err_o[2]); end
      end
      if (s == 4) begin
        nvec++;
        if (rdd1[2] !== 32'h0 || rdv1[2] !== 1'b1) begin
          nerr++; $display("FAIL range_read got %h/%0b want 00000000/1", rdd1[2], rdv1[2]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      cs = ($urandom_range(0, 7) != 0);
      wr1 = $urandom_range(0, 1); rd1 = $urandom_range(0, 1);
      wr2 = $urandom_range(0, 1); rd2 = $urandom_range(0, 1);
      addr1 = 4'($urandom_range(0, 15));
      addr2 = ($urandom_range(0, 3) == 0) ? addr1 : 4'($urandom_range(0, 15));
      wd1 = $urandom; wd2 = $urandom;
      be1 = 4'($urandom_range(0, 15)); be2 = 4'($urandom_range(0, 15));
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL random inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int c0;
    for (int s = 0; s < 9; s++) begin
      idle();
      rst = (s == 0 || s == 8);
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL midrst inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
    end
    idle(); c0 = 0;
    while (busy_o[0] === 1'b1 && c0 < 40) begin
      step(); c0++;
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL resweep inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
    end
    nvec++;
    if (c0 != 16) begin nerr++; $display("FAIL resweep_busy got %0d want 16", c0); end
    for (int a = 0; a < 16; a++) begin
      idle(); rd1 = 1'b1; addr1 = 4'(a); rd2 = 1'b1; addr2 = 4'(15 - a);
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (obs_vec(i) !== exp_vec(i)) begin nerr++; $display("FAIL reread inst%0d cyc%0d got %h want %h", i, cyc, obs_vec(i), exp_vec(i)); end
      end
      nvec++;
      if (rdd2[0] !== INIT) begin nerr++; $display("FAIL reread_word a=%0d got %h want %h", 15 - a, rdd2[0], INIT); end
    end
  endtask

  initial begin
    test_reset();
    test_dual_sweep();
    test_byte_lanes();
    test_rdw();
    test_gating();
    test_random();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
